// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer that serialises each popped word onto a UART line.
// Optional even parity bit: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_rd_ready,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic                  tx,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  cnt_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par;
`endif

    // Gated by reset so no word is popped while it would be thrown away.
    assign fifo_rd_en = (state == IDLE) & fifo_rd_ready & ~reset;
    assign busy       = (state != IDLE);
    assign shift_nxt  = shift >> 1;
    assign cnt_last   = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (fifo_rd_en)
                        state <= REQ;
                end
                REQ: begin
                    cnt <= '0;
                    if (fifo_rd_val) begin
                        shift <= fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
                        par   <= ^fifo_rd_data;
`endif
                        tx    <= 1'b0;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            shift   <= shift_nxt;
                            tx      <= shift_nxt[0];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO model, per-cycle line log and frame reference.
// Honours FIFO_UART_TX_PARITY_EN to expect the extra parity bit.
module tb_fifo_uart_tx;

    localparam int DW   = 8;
    localparam int C    = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB   = 11;
`else
    localparam int NB   = 10;
`endif
    localparam int FL   = NB * C;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_rd_ready = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_val = 1'b0;
    logic          tx;
    logic          busy;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_rd_ready(fifo_rd_ready),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_val  (fifo_rd_val),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          tx_l[MAXC];
    logic          busy_l[MAXC];
    logic          rden_l[MAXC];
    logic [DW-1:0] fq[$];
    bit            pend = 1'b0;
    bit            force_inv = 1'b0;

    // FIFO model (1-cycle read latency, stale rd_val/rd_data between pops)
    // plus a per-cycle log of the DUT outputs, indexed by posedge count.
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (force_inv) begin
                    fifo_rd_val = 1'b0;
                    void'(fq.pop_front());
                end else begin
                    fifo_rd_val  = 1'b1;
                    fifo_rd_data = fq.pop_front();
                end
            end
            fifo_rd_ready = (fq.size() > 0);
            #1;
            if (cyc < MAXC) begin
                tx_l[cyc]   = tx;
                busy_l[cyc] = busy;
                rden_l[cyc] = fifo_rd_en;
            end
            if (fifo_rd_en === 1'b1) begin
                checks++;
                if (!fifo_rd_ready) begin
                    errors++;
                    $display("FAIL rd_en_when_empty cyc=%0d got rd_en=1 want 0", cyc);
                end
                pend = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference frame: start 0, data LSB first, [even parity], stop 1.
    function automatic logic [NB-1:0] ref_frame(input logic [DW-1:0] w);
        logic [NB-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[i+1] = w[i];
`ifdef FIFO_UART_TX_PARITY_EN
        f[DW+1] = ^w;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // Bits read off the log from start cycle s; a bit that is not steady
    // for its whole bit time reads back as x.
    function automatic logic [NB-1:0] cap_frame(input int s);
        logic [NB-1:0] f;
        logic          v;
        f = 'x;
        if (s < 0 || s + FL >= MAXC) return f;
        for (int i = 0; i < NB; i++) begin
            v = tx_l[s + i*C];
            for (int k = 1; k < C; k++)
                if (tx_l[s + i*C + k] !== v) v = 1'bx;
            f[i] = v;
        end
        return f;
    endfunction

    function automatic int count_rden(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b && c < MAXC; c++)
            if (rden_l[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int nth_rden(input int a, input int b, input int n);
        int k = 0;
        for (int c = a; c <= b && c < MAXC; c++)
            if (rden_l[c] === 1'b1) begin
                if (k == n) return c;
                k++;
            end
        return -1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(6);
        for (int c = 1; c <= cyc; c++) begin
            checks++;
            if (tx_l[c] !== 1'b1 || busy_l[c] !== 1'b0 || rden_l[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got tx=%b busy=%b rd_en=%b want 1 0 0",
                         c, tx_l[c], busy_l[c], rden_l[c]);
            end
        end
    endtask

    task automatic test_single();
        int c0, t, n;
        logic [NB-1:0] got, exp;
        c0 = cyc;
        fq.push_back(8'hA5);
        step(FL + 12);
        n = count_rden(c0, cyc);
        t = nth_rden(c0, cyc, 0);
        checks++;
        if (n != 1 || t < 0) begin
            errors++;
            $display("FAIL single_rd_en_count got %0d want 1", n);
            return;
        end
        checks++;
        if (tx_l[t+1] !== 1'b1 || busy_l[t] !== 1'b0) begin
            errors++;
            $display("FAIL single_req_cycle got tx=%b busy_at_T=%b want 1 0",
                     tx_l[t+1], busy_l[t]);
        end
        got = cap_frame(t + 2);
        exp = ref_frame(8'hA5);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL single_frame got %b want %b", got, exp);
        end
        for (int c = t + 1; c <= t + 1 + FL; c++) begin
            checks++;
            if (busy_l[c] !== 1'b1) begin
                errors++;
                $display("FAIL single_busy cyc=T+%0d got %b want 1", c - t, busy_l[c]);
            end
        end
        checks++;
        if (busy_l[t+2+FL] !== 1'b0 || tx_l[t+2+FL] !== 1'b1) begin
            errors++;
            $display("FAIL single_end got busy=%b tx=%b want 0 1",
                     busy_l[t+2+FL], tx_l[t+2+FL]);
        end
    endtask

    task automatic test_back_to_back();
        int c0, t0, t1, n;
        logic [NB-1:0] got;
        c0 = cyc;
        fq.push_back(8'h01);
        fq.push_back(8'hFF);
        step(2 * FL + 30);
        n  = count_rden(c0, cyc);
        t0 = nth_rden(c0, cyc, 0);
        t1 = nth_rden(c0, cyc, 1);
        checks++;
        if (n != 2 || t1 < 0) begin
            errors++;
            $display("FAIL b2b_rd_en_count got %0d want 2", n);
            return;
        end
        checks++;
        if (t1 - t0 != FL + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", t1 - t0, FL + 2);
        end
        checks++;
        if (tx_l[t0+2+FL] !== 1'b1 || tx_l[t0+3+FL] !== 1'b1 || tx_l[t1+2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got %b%b then %b want 11 then 0",
                     tx_l[t0+2+FL], tx_l[t0+3+FL], tx_l[t1+2]);
        end
        got = cap_frame(t0 + 2);
        checks++;
        if (got !== ref_frame(8'h01)) begin
            errors++;
            $display("FAIL b2b_frame0 got %b want %b", got, ref_frame(8'h01));
        end
        got = cap_frame(t1 + 2);
        checks++;
        if (got !== ref_frame(8'hFF)) begin
            errors++;
            $display("FAIL b2b_frame1 got %b want %b", got, ref_frame(8'hFF));
        end
    endtask

    task automatic test_invalid();
        int c0, n, nb;
        c0 = cyc;
        force_inv = 1'b1;
        fq.push_back(8'h77);
        step(6);
        force_inv = 1'b0;
        step(FL);
        n  = count_rden(c0, cyc);
        nb = 0;
        for (int c = c0; c <= cyc; c++) begin
            if (busy_l[c] === 1'b1) nb++;
            checks++;
            if (tx_l[c] !== 1'b1) begin
                errors++;
                $display("FAIL invalid_tx cyc=%0d got %b want 1", c, tx_l[c]);
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL invalid_rd_en_count got %0d want 1", n);
        end
        checks++;
        if (nb != 1) begin
            errors++;
            $display("FAIL invalid_busy_cycles got %0d want 1", nb);
        end
    endtask

    task automatic test_reset_mid();
        int c0, c1, t, r, n;
        logic [NB-1:0] got;
        c0 = cyc;
        t  = -1;
        fq.push_back(8'h3C);
        for (int i = 0; i < 10 && t < 0; i++) begin
            step(1);
            if (rden_l[cyc] === 1'b1) t = cyc;
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL rstmid_no_rd_en got none want 1 within 10 cycles");
            return;
        end
        step(t + 3 + 4*C - cyc);
        reset = 1'b1;
        step(1);
        r = cyc;
        checks++;
        if (busy_l[r-1] !== 1'b1 || tx_l[r-1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_inflight got busy=%b tx=%b want 1 1 (data bit3)",
                     busy_l[r-1], tx_l[r-1]);
        end
        checks++;
        if (tx_l[r] !== 1'b1 || busy_l[r] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got tx=%b busy=%b want 1 0", tx_l[r], busy_l[r]);
        end
        step(1);
        reset = 1'b0;
        c1 = cyc;
        fq.push_back(8'h55);
        step(FL + 12);
        n = count_rden(c1 + 1, cyc);
        t = nth_rden(c1 + 1, cyc, 0);
        checks++;
        if (n != 1 || t < 0) begin
            errors++;
            $display("FAIL rstmid_repop got %0d rd_en want 1", n);
            return;
        end
        got = cap_frame(t + 2);
        checks++;
        if (got !== ref_frame(8'h55)) begin
            errors++;
            $display("FAIL rstmid_frame got %b want %b", got, ref_frame(8'h55));
        end
        checks++;
        if (count_rden(c0, c1) != 1) begin
            errors++;
            $display("FAIL rstmid_first_pops got %0d want 1", count_rden(c0, c1));
        end
    endtask

    task automatic test_refill();
        int c0, t0, t1, n;
        logic [NB-1:0] got;
        c0 = cyc;
        fq.push_back(8'hC3);
        step(20);
        fq.push_back(8'h5A);
        step(2 * FL + 20);
        n  = count_rden(c0, cyc);
        t0 = nth_rden(c0, cyc, 0);
        t1 = nth_rden(c0, cyc, 1);
        checks++;
        if (n != 2 || t1 < 0) begin
            errors++;
            $display("FAIL refill_rd_en_count got %0d want 2", n);
            return;
        end
        checks++;
        if (t1 != t0 + FL + 2) begin
            errors++;
            $display("FAIL refill_rd_en_time got T+%0d want T+%0d", t1 - t0, FL + 2);
        end
        got = cap_frame(t1 + 2);
        checks++;
        if (got !== ref_frame(8'h5A)) begin
            errors++;
            $display("FAIL refill_frame got %b want %b", got, ref_frame(8'h5A));
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w;
        logic [NB-1:0] got;
        int c0, n, t, tp;
        for (int r = 0; r < 5; r++) begin
            exp_q.delete();
            n  = $urandom_range(1, 3);
            c0 = cyc;
            for (int i = 0; i < n; i++) begin
                w = DW'($urandom);
                exp_q.push_back(w);
                fq.push_back(w);
            end
            step(n * (FL + 2) + 12);
            checks++;
            if (count_rden(c0, cyc) != n) begin
                errors++;
                $display("FAIL rand_rd_en_count round=%0d got %0d want %0d",
                         r, count_rden(c0, cyc), n);
                continue;
            end
            tp = -1;
            for (int i = 0; i < n; i++) begin
                t   = nth_rden(c0, cyc, i);
                got = cap_frame(t + 2);
                checks++;
                if (got !== ref_frame(exp_q[i])) begin
                    errors++;
                    $display("FAIL rand_frame round=%0d word=%0d got %b want %b",
                             r, i, got, ref_frame(exp_q[i]));
                end
                if (tp >= 0) begin
                    checks++;
                    if (t - tp != FL + 2) begin
                        errors++;
                        $display("FAIL rand_spacing round=%0d got %0d want %0d",
                                 r, t - tp, FL + 2);
                    end
                end
                tp = t;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        test_refill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
